// File: rtl/irq_pkg.sv
// Shared sizing, types and dispatch state encoding for the interrupt dispatcher.
package irq_pkg;

    localparam int NumIrq     = 8;
    localparam int PrioWidth  = 3;
    localparam int StackDepth = 4;

    localparam int IdxW   = $clog2(NumIrq);
    localparam int DepthW = $clog2(StackDepth + 1);
    localparam int SlotW  = $clog2(StackDepth);

    typedef logic [IdxW-1:0]      IrqIdx;
    typedef logic [PrioWidth-1:0] IrqPrio;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ
    } DispState;

endpackage

// File: rtl/irq_prio_stack.sv
// Priority stack of preempted handler levels; a simultaneous push and pop
// replaces the top entry in place.
module irq_prio_stack
    import irq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  IrqPrio            i_data,
    output IrqPrio            o_top,
    output logic [DepthW-1:0] o_depth,
    output logic              o_full,
    output logic              o_empty
);

    IrqPrio            r_mem [StackDepth];
    logic [DepthW-1:0] r_depth;

    logic              w_full;
    logic              w_empty;
    logic              w_do_pop;
    logic              w_do_push;
    logic [SlotW-1:0]  w_top_slot;
    logic [SlotW-1:0]  w_push_slot;

    assign w_full      = (r_depth == DepthW'(StackDepth));
    assign w_empty     = (r_depth == {DepthW{1'b0}});
    assign w_do_pop    = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full stack is fine then.
    assign w_do_push   = i_push && (!w_full || w_do_pop);
    assign w_top_slot  = SlotW'(r_depth - DepthW'(1));
    assign w_push_slot = SlotW'(r_depth);

    // Stack storage and depth counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth <= {DepthW{1'b0}};
            for (int i = 0; i < StackDepth; i++) begin
                r_mem[i] <= {PrioWidth{1'b0}};
            end
        end else begin
            case ({w_do_push, w_do_pop})
                2'b11: r_mem[w_top_slot] <= i_data;
                2'b10: begin
                    r_mem[w_push_slot] <= i_data;
                    r_depth            <= r_depth + DepthW'(1);
                end
                2'b01: r_depth <= r_depth - DepthW'(1);
                default: r_depth <= r_depth;
            endcase
        end
    end

    assign o_top   = w_empty ? {PrioWidth{1'b0}} : r_mem[w_top_slot];
    assign o_depth = r_depth;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: pending latch, per-line config, priority selection,
// valid/ack request handshake and nested-level tracking.
module irq_dispatch
    import irq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NumIrq-1:0]    irq_set_i,
    input  logic                 cfg_we_i,
    input  IrqIdx                cfg_idx_i,
    input  IrqPrio               cfg_prio_i,
    input  logic                 cfg_en_i,
    output logic                 irq_req_o,
    output IrqIdx                irq_id_o,
    output IrqPrio               irq_prio_o,
    input  logic                 irq_ack_i,
    input  logic                 irq_ret_i,
    output IrqPrio               level_o,
    output logic [DepthW-1:0]    depth_o,
    output logic [NumIrq-1:0]    pending_o,
    output logic                 ret_err_o
);

    DispState          r_state;
    logic              r_req;
    IrqIdx             r_id;
    IrqPrio            r_req_prio;
    logic              r_ret_err;
    logic [NumIrq-1:0] r_pending;
    logic [NumIrq-1:0] r_en;
    IrqPrio            r_prio [NumIrq];

    IrqPrio            w_level;
    logic [DepthW-1:0] w_depth;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic [NumIrq-1:0] w_clr;
    logic [NumIrq-1:0] w_elig;
    logic              w_any;
    logic              w_take;
    IrqIdx             w_sel_id;
    IrqPrio            w_sel_prio;

    assign w_push = (r_state == REQ) && irq_ack_i;
    assign w_clr  = w_push ? (NumIrq'(1) << r_id) : {NumIrq{1'b0}};

    irq_prio_stack u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (irq_ret_i),
        .i_data  (r_req_prio),
        .o_top   (w_level),
        .o_depth (w_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Per-line eligibility; priority 0 can never exceed a level and so never fires.
    always_comb begin
        w_elig = {NumIrq{1'b0}};
        for (int i = 0; i < NumIrq; i++) begin
            w_elig[i] = r_pending[i] && r_en[i] && (r_prio[i] > w_level) && !w_full;
        end
    end

    // Highest priority wins; the ascending scan with >= lets the higher index win ties.
    always_comb begin
        w_any      = 1'b0;
        w_take     = 1'b0;
        w_sel_id   = {IdxW{1'b0}};
        w_sel_prio = {PrioWidth{1'b0}};
        for (int i = 0; i < NumIrq; i++) begin
            w_take     = w_elig[i] && (!w_any || (r_prio[i] >= w_sel_prio));
            w_sel_id   = w_take ? IrqIdx'(i) : w_sel_id;
            w_sel_prio = w_take ? r_prio[i] : w_sel_prio;
            w_any      = w_any || w_take;
        end
    end

    // Pending latch: a same-cycle set beats the acknowledge clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= {NumIrq{1'b0}};
        end else begin
            r_pending <= (r_pending & ~w_clr) | irq_set_i;
        end
    end

    // Line configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en <= {NumIrq{1'b0}};
            for (int i = 0; i < NumIrq; i++) begin
                r_prio[i] <= {PrioWidth{1'b0}};
            end
        end else if (cfg_we_i) begin
            r_en[cfg_idx_i]   <= cfg_en_i;
            r_prio[cfg_idx_i] <= cfg_prio_i;
        end
    end

    // Request handshake FSM; the captured request is frozen until acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_id       <= {IdxW{1'b0}};
            r_req_prio <= {PrioWidth{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_req      <= 1'b1;
                        r_id       <= w_sel_id;
                        r_req_prio <= w_sel_prio;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack_i) begin
                        r_req   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Return with nothing on the stack is flagged for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ret_err <= 1'b0;
        end else begin
            r_ret_err <= irq_ret_i && w_empty;
        end
    end

    assign irq_req_o  = r_req;
    assign irq_id_o   = r_id;
    assign irq_prio_o = r_req_prio;
    assign level_o    = w_level;
    assign depth_o    = w_depth;
    assign pending_o  = r_pending;
    assign ret_err_o  = r_ret_err;

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed bench for irq_dispatch with a request scoreboard.
module tb_irq_dispatch;
    import irq_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [NumIrq-1:0] irq_set_i;
    logic              cfg_we_i;
    IrqIdx             cfg_idx_i;
    IrqPrio            cfg_prio_i;
    logic              cfg_en_i;
    logic              irq_req_o;
    IrqIdx             irq_id_o;
    IrqPrio            irq_prio_o;
    logic              irq_ack_i;
    logic              irq_ret_i;
    IrqPrio            level_o;
    logic [DepthW-1:0] depth_o;
    logic [NumIrq-1:0] pending_o;
    logic              ret_err_o;

    typedef struct packed {
        logic [IdxW-1:0]      id;
        logic [PrioWidth-1:0] prio;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    irq_dispatch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_set_i  (irq_set_i),
        .cfg_we_i   (cfg_we_i),
        .cfg_idx_i  (cfg_idx_i),
        .cfg_prio_i (cfg_prio_i),
        .cfg_en_i   (cfg_en_i),
        .irq_req_o  (irq_req_o),
        .irq_id_o   (irq_id_o),
        .irq_prio_o (irq_prio_o),
        .irq_ack_i  (irq_ack_i),
        .irq_ret_i  (irq_ret_i),
        .level_o    (level_o),
        .depth_o    (depth_o),
        .pending_o  (pending_o),
        .ret_err_o  (ret_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int idx, input int prio, input logic en);
        cfg_we_i   = 1'b1;
        cfg_idx_i  = IrqIdx'(idx);
        cfg_prio_i = IrqPrio'(prio);
        cfg_en_i   = en;
        cyc(1);
        cfg_we_i   = 1'b0;
    endtask

    task automatic set_line(input int idx, input int prio, input logic expect_it);
        exp_t e;
        e.id   = IrqIdx'(idx);
        e.prio = IrqPrio'(prio);
        if (expect_it) q.push_back(e);
        irq_set_i = NumIrq'(1) << idx;
        cyc(1);
        irq_set_i = '0;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check({tag, "_id"}, 32'(irq_id_o), 32'(e.id));
            check({tag, "_prio"}, 32'(irq_prio_o), 32'(e.prio));
        end
    endtask

    task automatic expect_req(input string tag);
        int n = 0;
        while (irq_req_o !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        check({tag, "_req"}, 32'(irq_req_o), 32'd1);
        pop_check(tag);
    endtask

    task automatic do_ack();
        irq_ack_i = 1'b1;
        cyc(1);
        irq_ack_i = 1'b0;
    endtask

    task automatic do_ret();
        irq_ret_i = 1'b1;
        cyc(1);
        irq_ret_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_set_i = '0; cfg_we_i = 1'b0; cfg_idx_i = '0;
        cfg_prio_i = '0; cfg_en_i = 1'b0; irq_ack_i = 1'b0; irq_ret_i = 1'b0;
        #2;
        check("rst_req", 32'(irq_req_o), 32'd0);
        check("rst_id", 32'(irq_id_o), 32'd0);
        check("rst_pending", 32'(pending_o), 32'd0);
        check("rst_depth", 32'(depth_o), 32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_ret_err", 32'(ret_err_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);

        // Single interrupt with exact latency
        cfg(3, 2, 1'b1);
        set_line(3, 2, 1'b1);
        check("single_pend_c1", 32'(pending_o), 32'h08);
        check("single_noreq_c1", 32'(irq_req_o), 32'd0);
        cyc(1);
        check("single_req_c2", 32'(irq_req_o), 32'd1);
        pop_check("single");
        cyc(1);
        check("single_hold_c3", 32'(irq_req_o), 32'd1);
        cyc(1);
        do_ack();
        check("single_ack_req", 32'(irq_req_o), 32'd0);
        check("single_ack_pend", 32'(pending_o[3]), 32'd0);
        check("single_ack_level", 32'(level_o), 32'd2);
        check("single_ack_depth", 32'(depth_o), 32'd1);
        do_ret();
        check("single_ret_level", 32'(level_o), 32'd0);
        check("single_ret_depth", 32'(depth_o), 32'd0);

        // Arbitration and ties
        cfg(1, 5, 1'b1);
        cfg(6, 5, 1'b1);
        cfg(2, 7, 1'b1);
        q.push_back('{id: 3'd2, prio: 3'd7});
        q.push_back('{id: 3'd6, prio: 3'd5});
        q.push_back('{id: 3'd1, prio: 3'd5});
        irq_set_i = 8'b0100_0110;
        cyc(1);
        irq_set_i = '0;
        for (int k = 0; k < 3; k++) begin
            expect_req($sformatf("arb%0d", k));
            do_ack();
            do_ret();
        end

        // Nesting and preemption threshold
        cfg(4, 4, 1'b1);
        set_line(4, 4, 1'b1);
        expect_req("nest_l4");
        do_ack();
        cfg(0, 4, 1'b1);
        set_line(0, 4, 1'b0);
        cyc(4);
        check("nest_eqprio_noreq", 32'(irq_req_o), 32'd0);
        check("nest_eqprio_pend", 32'(pending_o[0]), 32'd1);
        cfg(5, 6, 1'b1);
        set_line(5, 6, 1'b1);
        expect_req("nest_l5");
        do_ack();
        check("nest_depth2", 32'(depth_o), 32'd2);
        check("nest_level6", 32'(level_o), 32'd6);
        do_ret();
        check("nest_ret1_level", 32'(level_o), 32'd4);
        cyc(2);
        check("nest_ret1_noreq", 32'(irq_req_o), 32'd0);
        q.push_back('{id: 3'd0, prio: 3'd4});
        do_ret();
        check("nest_ret2_level", 32'(level_o), 32'd0);
        expect_req("nest_l0");
        do_ack();
        do_ret();

        // Held request is immune to new arrivals, disables and cfg writes
        set_line(3, 2, 1'b1);
        expect_req("hold_l3");
        cfg(7, 7, 1'b1);
        set_line(7, 7, 1'b1);
        cfg(3, 2, 1'b0);
        cyc(2);
        check("hold_req", 32'(irq_req_o), 32'd1);
        check("hold_id", 32'(irq_id_o), 32'd3);
        check("hold_prio", 32'(irq_prio_o), 32'd2);
        do_ack();
        check("hold_ack_pend3", 32'(pending_o[3]), 32'd0);
        expect_req("hold_l7");
        do_ack();
        do_ret();
        do_ret();
        cfg(3, 2, 1'b1);

        // Fill the stack, then a pending eligible line must wait
        cfg(0, 1, 1'b1);
        cfg(4, 3, 1'b1);
        cfg(5, 4, 1'b1);
        set_line(0, 1, 1'b1); expect_req("fill0"); do_ack();
        set_line(3, 2, 1'b1); expect_req("fill1"); do_ack();
        set_line(4, 3, 1'b1); expect_req("fill2"); do_ack();
        set_line(5, 4, 1'b1); expect_req("fill3"); do_ack();
        check("full_depth", 32'(depth_o), 32'd4);
        check("full_level", 32'(level_o), 32'd4);
        set_line(2, 7, 1'b1);
        cyc(5);
        check("full_noreq", 32'(irq_req_o), 32'd0);
        check("full_pend2", 32'(pending_o[2]), 32'd1);
        do_ret();
        check("full_ret_depth", 32'(depth_o), 32'd3);
        expect_req("full_l2");
        do_ack();
        check("full_refill_level", 32'(level_o), 32'd7);
        repeat (4) do_ret();
        check("drain_depth", 32'(depth_o), 32'd0);
        do_ret();
        check("ret_err_pulse", 32'(ret_err_o), 32'd1);
        check("ret_err_depth", 32'(depth_o), 32'd0);
        cyc(1);
        check("ret_err_drop", 32'(ret_err_o), 32'd0);

        // Set and ack of the same line in one cycle
        set_line(3, 2, 1'b1);
        expect_req("setack");
        irq_ack_i = 1'b1;
        irq_set_i = 8'h08;
        cyc(1);
        irq_ack_i = 1'b0;
        irq_set_i = '0;
        check("setack_pend", 32'(pending_o[3]), 32'd1);
        check("setack_depth", 32'(depth_o), 32'd1);
        q.push_back('{id: 3'd3, prio: 3'd2});
        do_ret();
        expect_req("setack_again");
        do_ack();
        do_ret();

        // Asynchronous reset in the middle of a request
        set_line(5, 4, 1'b1);
        expect_req("rst_l5");
        do_ack();
        set_line(7, 7, 1'b1);
        expect_req("rst_l7");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req", 32'(irq_req_o), 32'd0);
        check("midrst_pend", 32'(pending_o), 32'd0);
        check("midrst_depth", 32'(depth_o), 32'd0);
        check("midrst_level", 32'(level_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        check("post_rst_req", 32'(irq_req_o), 32'd0);
        check("sb_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_dispatch.md
Name: irq_dispatch

Overview:
- Sequential interrupt dispatcher on the core side of the priority-selection path.
- Latches interrupt events into pending bits and holds per-line priority/enable configuration.
- Picks the highest-priority eligible line and presents it to the core over a valid/ack handshake.
- Tracks nested (preempted) handlers on a priority stack, so only strictly higher priorities preempt.

Parameters:
- NumIrq, 8, number of interrupt lines (power of 2).
- PrioWidth, 3, priority field width; priority 0 never interrupts.
- StackDepth, 4, maximum handler nesting depth.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- irq_set_i  in  NumIrq  per-line event pulse; sets the pending bit.
- cfg_we_i  in  1  config write strobe.
- cfg_idx_i  in  clog2(NumIrq)  line being configured.
- cfg_prio_i  in  PrioWidth  priority to write.
- cfg_en_i  in  1  enable to write.
- irq_req_o  out  1  interrupt request valid.
- irq_id_o  out  clog2(NumIrq)  requested line.
- irq_prio_o  out  PrioWidth  priority of the requested line.
- irq_ack_i  in  1  core accepts the request (handler entry).
- irq_ret_i  in  1  core handler exit pulse.
- level_o  out  PrioWidth  current running level (stack top, 0 if empty).
- depth_o  out  clog2(StackDepth+1)  number of stack entries.
- pending_o  out  NumIrq  pending bits.
- ret_err_o  out  1  one-cycle pulse: irq_ret_i received with an empty stack.

Behaviour:
- Reset (async, rst_n=0), all cleared:
  - pending, enables, priorities, stack and depth are 0.
  - irq_req_o, irq_id_o, irq_prio_o, ret_err_o are 0; state is IDLE.
- Pending bits:
  - Set on irq_set_i at the clock edge.
  - Cleared only when the line is acknowledged.
  - Set and ack-clear on the same line in the same cycle: set wins, pending stays 1.
- Eligibility: line is pending AND enabled AND prio > level AND depth < StackDepth.
- Selection:
  - Combinational over the registered state; highest priority wins.
  - Equal priorities: highest index wins.
- FSM IDLE:
  - If any line is eligible, register id/prio, assert irq_req_o, go to REQ.
  - Timing: irq_set_i pulse in cycle N gives pending in N+1 and irq_req_o high in N+2.
- FSM REQ:
  - irq_req_o, irq_id_o, irq_prio_o are held stable until irq_ack_i; no retraction.
  - A higher-priority arrival, a disable, or a cfg write does not change the held request.
- Ack (REQ with irq_ack_i=1):
  - Clear pending[id], push irq_prio_o onto the stack; depth+1, level becomes that prio.
  - Drop irq_req_o next cycle and go to IDLE.
  - irq_ack_i outside REQ is ignored.
- Ret (irq_ret_i=1):
  - Depth>0: pop, level becomes the new top (or 0).
  - Depth==0: stack unchanged, ret_err_o pulses for 1 cycle.
- Ack and ret in the same cycle: pop then push; depth unchanged, top replaced by the acked prio.
- Earliest next request: the cycle after the ack cycle is IDLE, so a new request can appear 2 cycles after the ack edge.
- Stack full (depth==StackDepth): no line is eligible, so the FSM stays IDLE with pending retained until a ret.
- Config write:
  - Takes effect at the clock edge.
  - The write affects selection from the next cycle and never the held request.
- Reset mid-handshake aborts everything immediately; there is no recovery state.

Decomposition:
- irq_pkg holds:
  - NumIrq, PrioWidth, StackDepth.
  - IrqIdx and IrqPrio typedefs.
  - The dispatch state enum {IDLE, REQ}.
- One sub-module, irq_prio_stack:
  - Push, pop, top, depth, full, empty.
  - Simultaneous push/pop replaces the top.
- Selection logic stays inline in irq_dispatch.

Test Plan:
- Single interrupt: cfg line 3 prio 2 en 1; pulse set[3] at cycle 0 -> req=1, id=3, prio=2 at cycle 2. Ack at cycle 4 -> req=0, pending[3]=0, level=2, depth=1. Ret -> level=0, depth=0.
- Arbitration and ties: lines 1 (prio 5), 6 (prio 5) and 2 (prio 7) all pending -> id=2 first. After ack/ret -> id=6, then id=1.
- Nesting and threshold: in handler at level 4, set line 0 with prio 4 -> no req. Set line 5 with prio 6 -> req id=5. Ack -> depth=2, level=6. Ret twice -> level 4, then 0; line 0 is then dispatched.
- Stability and disable: req held for id=3; raise line 7 (prio 7) and disable line 3 before ack -> id stays 3 until ack. Next request is id=7.
- Boundaries: fill the stack to depth 4 with a pending eligible line -> no req until a ret. Ret at depth 0 -> ret_err_o pulse, depth stays 0. Set[3] in the same cycle as ack of 3 -> pending[3] remains 1.
- Reset mid-REQ: assert rst_n=0 asynchronously while req=1 -> req, pending, depth and level all read 0 before the next clock edge.
